// File: rtl/rf_write_sched.sv
// rf_write_sched: register-file write-port scheduler.
// Load returns always own the write port. ALU writes that lose the port are
// parked in an in-order deferred-write FIFO. The FIFO forwards to execute and
// drains whenever no load is present. A DRAIN state stalls upstream once the
// FIFO fills.
// Optional statistics counters are built when RFWS_STATS_EN is defined;
// otherwise defer_cnt/stall_cnt are tied to zero.
module rf_write_sched #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_we,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_we,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        rf_we,
   output logic [4:0]  rf_a,
   output logic [31:0] rf_wd,
   output logic        stall_w,
   input  logic [4:0]  fwd_rs1,
   input  logic [4:0]  fwd_rs2,
   output logic        fwd_hit1,
   output logic        fwd_hit2,
   output logic [31:0] fwd_data1,
   output logic [31:0] fwd_data2,
   output logic [15:0] defer_cnt,
   output logic [15:0] stall_cnt
);

   typedef enum logic {NORMAL, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [2:0]  count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [4:0]  rd_q   [DEPTH];
   logic [4:0]  rd_d   [DEPTH];
   logic [31:0] data_q [DEPTH];
   logic [31:0] data_d [DEPTH];

   logic       ld_v, alu_v, empty, full, pop, direct, push;
   logic [2:0] cnt_pop;

   // Request qualification and port arbitration decisions
   always_comb begin
      ld_v   = ld_we && (ld_rd != 5'd0);
      alu_v  = alu_we && (alu_rd != 5'd0) && (state_q == NORMAL);
      empty  = (count_q == 3'd0);
      full   = (count_q == 3'(DEPTH));
      pop    = !ld_v && !empty;
      direct = alu_v && !ld_v && empty;
      push   = alu_v && !direct && !full;
   end

   // Write port mux: load, then FIFO head (killed head writes nothing), then direct ALU
   always_comb begin
      rf_we = 1'b0;
      rf_a  = 5'd0;
      rf_wd = 32'd0;
      if (ld_v) begin
         rf_we = 1'b1;
         rf_a  = ld_rd;
         rf_wd = ld_data;
      end else if (!empty) begin
         rf_we = vld_q[0];
         rf_a  = rd_q[0];
         rf_wd = data_q[0];
      end else if (direct) begin
         rf_we = 1'b1;
         rf_a  = alu_rd;
         rf_wd = alu_data;
      end
   end

   // FIFO next state: kill by load, shift on pop, append younger ALU write at tail
   always_comb begin
      vld_d  = vld_q;
      rd_d   = rd_q;
      data_d = data_q;
      if (ld_v) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_q[i] == ld_rd) vld_d[i] = 1'b0;
         end
      end
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            vld_d[i]  = vld_q[i+1];
            rd_d[i]   = rd_q[i+1];
            data_d[i] = data_q[i+1];
         end
         vld_d[DEPTH-1] = 1'b0;
      end
      cnt_pop = count_q - {2'b00, pop};
      if (push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(cnt_pop)) begin
               vld_d[i]  = 1'b1;
               rd_d[i]   = alu_rd;
               data_d[i] = alu_data;
            end
         end
      end
      count_d = cnt_pop + {2'b00, push};
   end

   // Drain FSM transitions, decided on the post-update occupancy
   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL: if (count_d == 3'(DEPTH)) state_d = DRAIN;
         DRAIN:  if (count_d == 3'd0)      state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   assign stall_w = (state_q == DRAIN);

   // Forwarding: scan oldest to youngest so the youngest valid match wins
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = 32'd0;
      fwd_data2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (fwd_rs1 != 5'd0) && (rd_q[i] == fwd_rs1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = data_q[i];
         end
         if (vld_q[i] && (fwd_rs2 != 5'd0) && (rd_q[i] == fwd_rs2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = data_q[i];
         end
      end
   end

   // Control state: reset discards every pending write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= NORMAL;
         count_q <= 3'd0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Entry payload; qualified by vld_q so it needs no reset
   always_ff @(posedge clk) begin
      rd_q   <= rd_d;
      data_q <= data_d;
   end

`ifdef RFWS_STATS_EN
   logic [15:0] defer_cnt_q, defer_cnt_d, stall_cnt_q, stall_cnt_d;

   // Saturating event counters
   always_comb begin
      defer_cnt_d = defer_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (push && (defer_cnt_q != 16'hFFFF))    defer_cnt_d = defer_cnt_q + 16'd1;
      if (stall_w && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         defer_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         defer_cnt_q <= defer_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign defer_cnt = defer_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign defer_cnt = 16'd0;
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// Testbench for rf_write_sched: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the write-port rules.
module tb_rf_write_sched;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_we, ld_we;
   logic [4:0]  alu_rd, ld_rd, fwd_rs1, fwd_rs2, rf_a;
   logic [31:0] alu_data, ld_data, rf_wd, fwd_data1, fwd_data2;
   logic        rf_we, stall_w, fwd_hit1, fwd_hit2;
   logic [15:0] defer_cnt, stall_cnt;

   always #5 clk = ~clk;

   rf_write_sched #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_we(ld_we), .ld_rd(ld_rd), .ld_data(ld_data),
      .rf_we(rf_we), .rf_a(rf_a), .rf_wd(rf_wd), .stall_w(stall_w),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .defer_cnt(defer_cnt), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          live;
   } ent_t;

   ent_t q[$];
   bit   m_drain;
   int   m_defer, m_stall;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_drain = 0;
      m_defer = 0;
      m_stall = 0;
   endtask

   // Youngest live queue entry with matching register
   task automatic model_fwd(input logic [4:0] rs, output bit hit, output logic [31:0] d);
      hit = 0;
      d   = 32'd0;
      if (rs != 5'd0)
         foreach (q[i]) if (q[i].live && q[i].rd == rs) begin hit = 1; d = q[i].data; end
   endtask

   // Compare every output against the model, then advance the model one cycle
   task automatic check_and_step();
      bit ldv, aluv, ew, h;
      logic [4:0]  ea;
      logic [31:0] ed, fd;
      int n0;
      ldv  = ld_we && ld_rd != 5'd0;
      aluv = alu_we && alu_rd != 5'd0 && !m_drain;
      ew = 0; ea = 5'd0; ed = 32'd0;
      if (ldv) begin ew = 1; ea = ld_rd; ed = ld_data; end
      else if (q.size() > 0) begin ew = q[0].live; ea = q[0].rd; ed = q[0].data; end
      else if (aluv) begin ew = 1; ea = alu_rd; ed = alu_data; end
      chk("rf_we", 32'(rf_we), 32'(ew));
      if (ew) begin
         chk("rf_a", 32'(rf_a), 32'(ea));
         chk("rf_wd", rf_wd, ed);
      end
      chk("stall_w", 32'(stall_w), 32'(m_drain));
      model_fwd(fwd_rs1, h, fd);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
      if (h) chk("fwd_data1", fwd_data1, fd);
      model_fwd(fwd_rs2, h, fd);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
      if (h) chk("fwd_data2", fwd_data2, fd);
`ifdef RFWS_STATS_EN
      chk("defer_cnt", 32'(defer_cnt), 32'(m_defer));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`else
      chk("defer_cnt", 32'(defer_cnt), 32'd0);
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      // model update
      n0 = q.size();
      if (m_drain && m_stall < 65535) m_stall++;
      if (ldv) foreach (q[i]) if (q[i].rd == ld_rd) q[i].live = 0;
      if (!ldv && n0 > 0) void'(q.pop_front());
      if (aluv && !(!ldv && n0 == 0) && n0 < DEPTH) begin
         q.push_back('{rd: alu_rd, data: alu_data, live: 1'b1});
         if (m_defer < 65535) m_defer++;
      end
      if (!m_drain && q.size() == DEPTH) m_drain = 1;
      else if (m_drain && q.size() == 0) m_drain = 0;
   endtask

   task automatic tick(input bit awe, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lwe, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
      @(negedge clk);
      alu_we = awe; alu_rd = ard; alu_data = ad;
      ld_we = lwe; ld_rd = lrd; ld_data = ldd;
      fwd_rs1 = rs1; fwd_rs2 = rs2;
      #1;
      check_and_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
   endtask

   initial begin
      reset = 1'b1;
      alu_we = 0; alu_rd = '0; alu_data = '0;
      ld_we = 0; ld_rd = '0; ld_data = '0;
      fwd_rs1 = '0; fwd_rs2 = '0;
      model_clear();
      #12;
      chk("rst_stall_w", 32'(stall_w), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_defer", 32'(defer_cnt), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // direct write
      tick(1, 5'd5, 32'h11, 0, 5'd0, 32'd0, 5'd5, 5'd0);
      chk("direct_rf_a", 32'(rf_a), 32'd5);
      chk("direct_rf_wd", rf_wd, 32'h11);
      // collision then deferred write, forwarding in between
      tick(1, 5'd4, 32'hBB, 1, 5'd3, 32'hAA, 5'd4, 5'd3);
      chk("coll_rf_a", 32'(rf_a), 32'd3);
      tick(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd4, 5'd0);
      chk("defer_fwd_hit", 32'(fwd_hit1), 32'd1);
      chk("defer_rf_wd", rf_wd, 32'hBB);
      idle(1);
      // fill and drain
      tick(1, 5'd8, 32'h80, 1, 5'd1, 32'h10, 5'd8, 5'd0);
      tick(1, 5'd9, 32'h90, 1, 5'd2, 32'h20, 5'd8, 5'd9);
      tick(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd9, 5'd0);
      chk("fill_stall_w", 32'(stall_w), 32'd1);
      idle(2);
      chk("drain_done_stall_w", 32'(stall_w), 32'd0);
      // kill
      tick(1, 5'd7, 32'h1, 1, 5'd6, 32'h6, 5'd7, 5'd0);
      tick(0, 5'd0, 32'd0, 1, 5'd7, 32'h2, 5'd7, 5'd0);
      chk("kill_ld_wd", rf_wd, 32'h2);
      tick(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0);
      chk("kill_pop_we", 32'(rf_we), 32'd0);
      chk("kill_fwd_hit", 32'(fwd_hit1), 32'd0);
      // x0 filter
      tick(1, 5'd0, 32'hDEAD, 1, 5'd3, 32'h33, 5'd0, 5'd0);
      idle(1);
      chk("x0_rf_we", 32'(rf_we), 32'd0);
      // reset mid-drain
      tick(1, 5'd10, 32'hA0, 1, 5'd1, 32'h1, 5'd0, 5'd0);
      tick(1, 5'd11, 32'hB0, 1, 5'd2, 32'h2, 5'd0, 5'd0);
      tick(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd10, 5'd11);
      @(negedge clk);
      alu_we = 0; ld_we = 0; fwd_rs1 = 5'd10; fwd_rs2 = 5'd11;
      reset = 1'b1;
      #1;
      chk("rstmid_stall_w", 32'(stall_w), 32'd0);
      chk("rstmid_rf_we", 32'(rf_we), 32'd0);
      chk("rstmid_fwd_hit1", 32'(fwd_hit1), 32'd0);
      chk("rstmid_fwd_hit2", 32'(fwd_hit2), 32'd0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      idle(3);

      // random traffic
      for (int n = 0; n < 600; n++)
         tick(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              bit'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
